// File: rtl/mc_controller.sv
// mc_controller: decoder, sequencing FSM, condition logic and NZCV flags
// for the shared-memory multicycle ARM-subset datapath.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  state_t state, cur, next;
  logic [3:0] cond, rd, flags;
  logic [1:0] op, alu_dec;
  logic [5:0] funct;
  logic cond_ex, cond_ex_r, no_write, exec, pc_w, mem_w, reg_w, ir_w, unused;
  assign {cond, op, funct} = Instr[19:8];
  assign rd = Instr[3:0];
  assign unused = ^Instr[7:4];
  // Reset overrides the state so outputs show the FETCH decode immediately
  assign cur = reset ? FETCH : state;
  assign exec = (cur == EXECUTER) || (cur == EXECUTEI);
  assign ImmSrc = (op == 2'b11) ? 2'b00 : op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  always_comb begin
    case (cond)
      4'h0: cond_ex = flags[2];
      4'h1: cond_ex = ~flags[2];
      4'h2: cond_ex = flags[1];
      4'h3: cond_ex = ~flags[1];
      4'h4: cond_ex = flags[3];
      4'h5: cond_ex = ~flags[3];
      4'h6: cond_ex = flags[0];
      4'h7: cond_ex = ~flags[0];
      4'h8: cond_ex = flags[1] & ~flags[2];
      4'h9: cond_ex = ~(flags[1] & ~flags[2]);
      4'ha: cond_ex = flags[3] == flags[0];
      4'hb: cond_ex = flags[3] != flags[0];
      4'hc: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'hd: cond_ex = ~(~flags[2] & (flags[3] == flags[0]));
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  always_comb begin
    alu_dec = 2'b00;
    no_write = 1'b0;
    case (funct[4:1])
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin
        alu_dec = 2'b01;
        no_write = 1'b1;
      end
      default: alu_dec = 2'b00;
    endcase
  end
  always_comb begin
    next = FETCH;
    pc_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    ir_w = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    ALUControl = 2'b00;
    case (cur)
      FETCH: begin
        next = DECODE;
        ir_w = 1'b1;
        pc_w = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        next = (op == 2'b01) ? MEMADR :
               (op == 2'b00) ? (funct[5] ? EXECUTEI : EXECUTER) :
               (op == 2'b10) ? BRANCH : FETCH;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        next = funct[0] ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        next = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = cond_ex_r;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w = cond_ex_r;
      end
      EXECUTER: begin
        next = ALUWB;
        ALUControl = alu_dec;
      end
      EXECUTEI: begin
        next = ALUWB;
        ALUSrcB = 2'b01;
        ALUControl = alu_dec;
      end
      ALUWB: begin
        reg_w = cond_ex_r & ~no_write;
        pc_w = reg_w & (rd == 4'hf);
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        pc_w = cond_ex_r;
      end
      default: next = FETCH;
    endcase
    PCWrite = pc_w & ~reset;
    MemWrite = mem_w & ~reset;
    RegWrite = reg_w & ~reset;
    IRWrite = ir_w & ~reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state <= next;
      if (cur == DECODE) cond_ex_r <= cond_ex;
      // CMP (no_write) always sets flags; logical ops leave C and V alone
      if (exec & cond_ex_r & (funct[0] | no_write)) begin
        flags[3:2] <= ALUFlags[3:2];
        if (~alu_dec[1]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle ARM-subset processor.
- Contains the instruction decoder, the main sequencing FSM, the condition-evaluation logic, an NZCV flag register and a registered condition-pass bit.
- Drives every mux select and write enable of the shared-memory multicycle datapath.
- Supports data-processing ops (ADD, SUB, AND, ORR, CMP; register or immediate), LDR/STR with immediate offset, and B.

Parameters:
- None. Instruction subset and encodings are fixed.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  IR bits [31:12]; Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut/Result
- RegSrc  out  2  register-file read-address selects
- ALUSrcA  out  1  0=RD1 latch, 1=PC
- ALUSrcB  out  2  00=RD2 latch, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  extender mode
- ALUControl  out  2  00=add, 01=sub, 10=and, 11=or

Behaviour:
- Reset: state=FETCH, Flags=0000, CondExR=0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - All other outputs show FETCH decode.
  - Reset asserted in any state aborts the instruction on the next edge; no partial write occurs after that edge.
- FSM states and transitions:
  - FETCH -> DECODE
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined op, no side effects).
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
- Latency: DP 4 cycles, LDR 5, STR 4, B 3, undefined op 2.
- State outputs (unlisted signals are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondExR.
  - MEMWR: AdrSrc=1, MemWrite=CondExR.
  - EXECUTER: ALUSrcB=00, ALU decode active.
  - EXECUTEI: ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite; PCWrite=1 if Rd=1111 & RegWrite.
  - BRANCH: ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExR.
- ImmSrc=Op, valid in all states; Op=11 gives 00.
- RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
- ALU decode (EXECUTE states only), by Funct[4:1]:
  - 0100 -> 00 (ADD)
  - 0010 -> 01 (SUB)
  - 0000 -> 10 (AND)
  - 1100 -> 11 (ORR)
  - 1010 -> 01 with NoWrite=1 (CMP)
  - any other code -> 00, NoWrite=0
- Condition evaluation (CondEx, combinational from the registered Flags), by Cond:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~(C&~Z), GE N==V, LT N!=V
  - GT ~Z&(N==V), LE ~(~Z&(N==V)), AL 1
  - Cond=1111 -> 0, never X.
- CondExR loads CondEx only in DECODE and holds for the rest of the instruction.
- Flags update only at the end of EXECUTER/EXECUTEI, and only when Funct[0]=1 (S bit) & CondExR:
  - {N,Z} always update.
  - {C,V} update only when ALUControl is 00 or 01.
  - CMP always sets flags regardless of the S bit.
- A flag write in EXECUTE is visible to the next instruction's DECODE, never to the current ALUWB.

Test Plan:
- Reset, then ADD R1,R2,#5 (0xE2821005) -> states FETCH, DECODE, EXECUTEI, ALUWB, FETCH; EXECUTEI has ALUSrcB=01, ALUControl=00; RegWrite=1 only in ALUWB; Flags stay 0000.
- SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0100 in EXECUTEI -> Flags=0100. Then BEQ (0x0A000002) -> PCWrite=1 in BRANCH. Then BNE (0x1A000002) -> PCWrite=0 in BRANCH, 3 cycles total.
- LDR R1,[R0,#4] (0xE5910004) -> states MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles; RegSrc=10.
- With Z=1, STRNE (0x15810004) -> MemWrite=0 throughout MEMWR. With Z=0, the same instruction gives MemWrite=1 for exactly one cycle.
- CMP R0,R1 (0xE1500001) with ALUFlags=1011 -> RegWrite=0 in ALUWB, Flags=1011. ANDS (0xE0110002) with ALUFlags=0111 -> Flags=0111: C and V keep their prior values, N and Z update.
- Reset=1 during MEMRD of an LDR -> next state FETCH, Flags=0000, no RegWrite pulse. Op=11 instruction -> DECODE returns to FETCH with all write enables 0.
